// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake.
// One radix-2 shift-add / restoring-divide datapath shared by all M ops.
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        Funct,
  input  logic [DATA_W-1:0] InputA,
  input  logic [DATA_W-1:0] InputB,
  input  logic              Flush,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] Result,
  output logic              DivByZero,
  output logic              Overflow
);

  localparam int W     = DATA_W;
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic             neg_a, neg_b;
  logic [2*W-1:0]   acc;
  logic [W-1:0]     b;

  logic             accept, special, is_div;
  logic             signed_a, signed_b, sa, sb;
  logic             div_zero, div_ovf;
  logic [W-1:0]     mag_a, mag_b, spec_res;
  logic [W:0]       sum, r, rd;
  logic             ge;
  logic [2*W-1:0]   mul_step, div_step, prod;
  logic [W-1:0]     res_fix;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (Funct)
      3'd1, 3'd4, 3'd6: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      3'd2:    signed_a = 1'b1;
      default: ;
    endcase
  end

  assign is_div   = Funct[2];
  assign sa       = signed_a & InputA[W-1];
  assign sb       = signed_b & InputB[W-1];
  assign mag_a    = sa ? -InputA : InputA;
  assign mag_b    = sb ? -InputB : InputB;
  assign div_zero = is_div && (InputB == '0);
  assign div_ovf  = is_div && !Funct[0] && !div_zero
                    && (InputA == MIN) && (InputB == '1);
  assign special  = div_zero | div_ovf;
  assign accept   = InValid && InReady && !Flush;

  always_comb begin
    spec_res = '0;
    if (div_zero)
      spec_res = Funct[1] ? InputA : '1;
    else if (div_ovf)
      spec_res = Funct[1] ? '0 : InputA;
  end

  // acc holds {hi, lo}: product halves, or {remainder, dividend/quotient}
  assign sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b} : '0);
  assign mul_step = {sum, acc[W-1:1]};
  assign r        = {acc[2*W-1:W], acc[W-1]};
  assign ge       = r >= {1'b0, b};
  assign rd       = ge ? r - {1'b0, b} : r;
  assign div_step = {rd[W-1:0], acc[W-2:0], ge};

  assign prod = (neg_a ^ neg_b) ? -acc : acc;

  always_comb begin
    res_fix = '0;
    case (op)
      3'd0:             res_fix = prod[W-1:0];
      3'd1, 3'd2, 3'd3: res_fix = prod[2*W-1:W];
      3'd4, 3'd5:
        res_fix = (neg_a ^ neg_b) ? -acc[W-1:0] : acc[W-1:0];
      default:
        res_fix = neg_a ? -acc[2*W-1:W] : acc[2*W-1:W];
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(W-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (OutReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (Flush) state_nx = IDLE;
  end

  always_comb begin
    InReady  = (state == IDLE);
    OutValid = (state == DONE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt       <= '0;
      op        <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      acc       <= '0;
      b         <= '0;
      Result    <= '0;
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else if (Flush) begin
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op        <= Funct;
          neg_a     <= sa;
          neg_b     <= sb;
          acc       <= {{W{1'b0}}, mag_a};
          b         <= mag_b;
          cnt       <= '0;
          DivByZero <= div_zero;
          Overflow  <= div_ovf;
          if (special) Result <= spec_res;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= op[2] ? div_step : mul_step;
        end
        FIX:     Result <= res_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed M-ext cases, random ops,
// backpressure, flush and asynchronous reset.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN  = 32'h8000_0000;
  localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [2:0]   Funct = '0;
  logic [W-1:0] InputA = '0;
  logic [W-1:0] InputB = '0;
  logic         Flush = 1'b0;
  logic         OutValid;
  logic         OutReady = 1'b1;
  logic [W-1:0] Result;
  logic         DivByZero;
  logic         Overflow;

  mul_div_unit #(.DATA_W(W)) dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .Funct(Funct), .InputA(InputA), .InputB(InputB), .Flush(Flush),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .DivByZero(DivByZero), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] res;
    logic         dbz;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   rand_ready = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] bb);
    exp_t   e;
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(bb));
    e.dbz = f[2] && (bb == 0);
    e.ovf = (f == 3'd4 || f == 3'd6) && a == MIN && bb == ONES;
    e.lat = (e.dbz || e.ovf) ? 1 : W + 2;
    e.res = '0;
    case (f)
      3'd0: begin p = sa * sb; e.res = p[31:0]; end
      3'd1: begin p = sa * sb; e.res = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, bb}); e.res = p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, bb}; e.res = up[63:32]; end
      3'd4: begin
        if (e.dbz) e.res = ONES;
        else if (e.ovf) e.res = a;
        else begin p = sa / sb; e.res = p[31:0]; end
      end
      3'd5: e.res = e.dbz ? ONES : a / bb;
      3'd6: begin
        if (e.dbz) e.res = a;
        else if (e.ovf) e.res = '0;
        else begin p = sa % sb; e.res = p[31:0]; end
      end
      default: e.res = e.dbz ? a : a % bb;
    endcase
    return e;
  endfunction

  // Monitor: pops one expectation per handshake
  bit seen = 0;
  int lat_meas = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (!OutValid) seen = 0;
    if (OutValid && !seen) begin
      seen = 1;
      lat_meas = cyc - acc_cyc + 1;
    end
    if (OutValid && OutReady) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", Result);
      end else begin
        e = q.pop_front();
        chk("result", 64'(Result), 64'(e.res));
        chk("div_by_zero", 64'(DivByZero), 64'(e.dbz));
        chk("overflow", 64'(Overflow), 64'(e.ovf));
        chk("latency", 64'(lat_meas), 64'(e.lat));
      end
      seen = 0;
    end
  end

  initial forever begin
    @(posedge Clk);
    #1;
    if (rand_ready) OutReady = 1'($urandom_range(0, 1));
  end

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] bb, input bit push);
    int n = 0;
    @(negedge Clk);
    while (!InReady && n < 500) begin
      @(negedge Clk);
      n++;
    end
    if (!InReady) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got busy expected ready");
      return;
    end
    Funct = f;
    InputA = a;
    InputB = bb;
    InValid = 1'b1;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    acc_cyc = cyc;
    if (push) q.push_back(model(f, a, bb));
    InputA = $urandom;
    InputB = $urandom;
    Funct = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !InReady) && n < 3000) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return MIN;
      1:       return ONES;
      2:       return '0;
      3:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  n;
    bit  ov_any;
    #1;
    chk("rst_in_ready", 64'(InReady), 64'd1);
    chk("rst_out_valid", 64'(OutValid), 64'd0);
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_flags", 64'({DivByZero, Overflow}), 64'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
    issue(3'd1, MIN, MIN, 1);
    issue(3'd3, ONES, ONES, 1);
    issue(3'd2, ONES, ONES, 1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'd5, 32'hFFFF_FFFE, 32'd2, 1);
    issue(3'd7, 32'd10, 32'd3, 1);
    issue(3'd5, 32'd5, 32'd0, 1);
    issue(3'd6, 32'd5, 32'd0, 1);
    issue(3'd4, MIN, ONES, 1);
    issue(3'd6, MIN, ONES, 1);
    drain();

    // Backpressure in DONE
    OutReady = 1'b0;
    issue(3'd5, 32'd5, 32'd0, 1);
    n = 0;
    while (!OutValid && n < 100) begin
      @(negedge Clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 64'(OutValid), 64'd1);
      chk("bp_in_ready", 64'(InReady), 64'd0);
      chk("bp_result", 64'(Result), 64'(ONES));
      chk("bp_flags", 64'({DivByZero, Overflow}), 64'b10);
      @(negedge Clk);
    end
    @(posedge Clk);
    #1;
    OutReady = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("bp_release_ready", 64'(InReady), 64'd1);
    issue(3'd0, 32'd6, 32'd7, 1);
    drain();

    rand_ready = 1;
    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1);
    rand_ready = 0;
    @(posedge Clk);
    #1;
    OutReady = 1'b1;
    drain();

    // Flush 5 cycles into a DIV
    issue(3'd4, 32'd100, 32'd7, 0);
    repeat (4) @(posedge Clk);
    #1;
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    @(negedge Clk);
    chk("flush_in_ready", 64'(InReady), 64'd1);
    ov_any = 0;
    for (int i = 0; i < 45; i++) begin
      if (OutValid) ov_any = 1;
      @(negedge Clk);
    end
    chk("flush_no_output", 64'(ov_any), 64'd0);

    // Flush alongside InValid in IDLE: must not accept
    @(posedge Clk);
    #1;
    Funct = 3'd0;
    InValid = 1'b1;
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    Flush = 1'b0;
    @(negedge Clk);
    chk("flush_no_accept", 64'(InReady), 64'd1);

    // Asynchronous reset mid-CALC
    issue(3'd0, 32'd9, 32'd9, 0);
    repeat (10) @(posedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(InReady), 64'd1);
    chk("arst_out_valid", 64'(OutValid), 64'd0);
    chk("arst_result", 64'(Result), 64'd0);
    chk("arst_flags", 64'({DivByZero, Overflow}), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    issue(3'd0, 32'd3, 32'd4, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
